pwm_multi: RTL and testbench

Multi-channel PWM generator: NUM_CH outputs share one period counter, each with its own N-bit duty cycle, output polarity and channel enable. Duty cycle and alignment-mode updates are double-buffered and take effect only at a period boundary, so no output ever sees a glitched period. It replaces single-channel PWM instances in servo/LED/motor drive paths where several outputs must stay phase-locked.

---
 rtl/pwm_multi.sv | 104 ++++++++++
 tb/tb_pwm_multi.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/pwm_multi.sv
// Multi-channel PWM sharing one period counter. Duty and alignment mode are
// double-buffered and reload only at a period boundary or while the block is idle.
module pwm_multi #(
    parameter int NUM_CH           = 4,
    parameter int N                = 8,
    parameter int PERIOD_CLK_COUNT = 2000000
) (
    input  logic                                         clkIn,
    input  logic                                         rstIn,
    input  logic                                         enIn,
    input  logic                                         modeIn,
    input  logic [NUM_CH-1:0]                            chEnIn,
    input  logic [NUM_CH-1:0]                            polIn,
    input  logic                                         wrEnIn,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] wrChIn,
    input  logic [N-1:0]                                 wrDutyIn,
    output logic [NUM_CH-1:0]                            pwmOut,
    output logic                                         periodStartOut
);

    localparam int CNT_W = $clog2(PERIOD_CLK_COUNT);
    // One extra bit so the full period length itself is representable.
    localparam int CW = CNT_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PERIOD_CLK_COUNT - 1);
    localparam logic [CW-1:0]    STEP    = CW'(PERIOD_CLK_COUNT >> N);
    localparam logic [CW-1:0]    PER_W   = CW'(PERIOD_CLK_COUNT);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [N-1:0]      pend_q [NUM_CH];
    logic [N-1:0]      pend_d [NUM_CH];
    logic [N-1:0]      act_q  [NUM_CH];
    logic [N-1:0]      act_d  [NUM_CH];
    logic              mode_q, mode_d;
    logic [NUM_CH-1:0] pwm_q, pwm_d;
    logic              pstart_q, pstart_d;
    logic [NUM_CH-1:0] wr_hit;
    logic              boundary, reload;

    function automatic logic pwm_level(input logic [N-1:0]     duty,
                                       input logic [CNT_W-1:0] cnt,
                                       input logic             center);
        logic [CW-1:0] thr;
        logic [CW-1:0] lo;
        logic [CW-1:0] hi;
        logic [CW-1:0] c;
        thr = CW'(duty) * STEP;
        c   = CW'(cnt);
        lo  = (PER_W - thr) >> 1;
        hi  = lo + thr;
        if (center) begin
            return (c >= lo) && (c < hi);
        end
        return c < thr;
    endfunction

    always_comb begin
        boundary = enIn && (cnt_q == CNT_MAX);
        reload   = boundary || !enIn;
        cnt_d    = cnt_q;
        if (enIn) begin
            cnt_d = boundary ? '0 : cnt_q + CNT_W'(1);
        end
        mode_d   = reload ? modeIn : mode_q;
        pstart_d = enIn && (cnt_q == '0);
        wr_hit   = '0;
        pwm_d    = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            wr_hit[ch] = wrEnIn && (32'(wrChIn) == ch);
            pend_d[ch] = wr_hit[ch] ? wrDutyIn : pend_q[ch];
            // Taking pend_d lets a write on the reload edge bypass straight to active.
            act_d[ch]  = reload ? pend_d[ch] : act_q[ch];
            pwm_d[ch]  = (enIn && chEnIn[ch])
                       ? (pwm_level(act_q[ch], cnt_q, mode_q) ^ polIn[ch])
                       : polIn[ch];
        end
    end

    // Output stage: compare of the current count lands one clock later.
    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            cnt_q    <= '0;
            mode_q   <= 1'b0;
            pwm_q    <= '0;
            pstart_q <= 1'b0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                pend_q[ch] <= '0;
                act_q[ch]  <= '0;
            end
        end else begin
            cnt_q    <= cnt_d;
            mode_q   <= mode_d;
            pwm_q    <= pwm_d;
            pstart_q <= pstart_d;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                pend_q[ch] <= pend_d[ch];
                act_q[ch]  <= act_d[ch];
            end
        end
    end

    assign pwmOut         = pwm_q;
    assign periodStartOut = pstart_q;

endmodule

// File: tb/tb_pwm_multi.sv
// Directed bench for pwm_multi with a 1024-clock period and 8-bit duty (step 4).
module tb_pwm_multi;

    logic       clkIn = 1'b0;
    logic       rstIn, enIn, modeIn, wrEnIn;
    logic [3:0] chEnIn, polIn;
    logic [1:0] wrChIn;
    logic [7:0] wrDutyIn;
    logic [3:0] pwmOut;
    logic       periodStartOut;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int hc[4];
    int fh[4];
    int lh[4];
    int psc;

    always #5 clkIn = ~clkIn;

    pwm_multi #(.NUM_CH(4), .N(8), .PERIOD_CLK_COUNT(1024)) dut (
        .clkIn(clkIn), .rstIn(rstIn), .enIn(enIn), .modeIn(modeIn),
        .chEnIn(chEnIn), .polIn(polIn), .wrEnIn(wrEnIn), .wrChIn(wrChIn),
        .wrDutyIn(wrDutyIn), .pwmOut(pwmOut), .periodStartOut(periodStartOut)
    );

    task automatic tick();
        @(posedge clkIn);
        #1;
    endtask

    task automatic drive_write(input int ch, input int duty);
        wrEnIn   = 1'b1;
        wrChIn   = 2'(ch);
        wrDutyIn = 8'(duty);
    endtask

    // Aligns to a periodStartOut sample, then records one full period per channel.
    task automatic measure_period(input int w1, input int d1, input int w2, input int d2, input int wch);
        int k = 0;
        while (periodStartOut !== 1'b1 && k < 2100) begin
            tick();
            k++;
        end
        if (periodStartOut !== 1'b1) begin
            $display("FAIL period_align periodStartOut=%b expected 1 within 2100 cycles", periodStartOut);
            $fatal(1);
        end
        psc = 0;
        for (int c = 0; c < 4; c++) begin
            hc[c] = 0; fh[c] = -1; lh[c] = -1;
        end
        for (int i = 0; i < 1024; i++) begin
            if (periodStartOut === 1'b1) psc++;
            for (int c = 0; c < 4; c++) begin
                if (pwmOut[c] === 1'b1) begin
                    hc[c]++;
                    if (fh[c] < 0) fh[c] = i;
                    lh[c] = i;
                end
            end
            if (i == w1) drive_write(wch, d1);
            if (i == w2) drive_write(wch, d2);
            tick();
            wrEnIn = 1'b0;
        end
    endtask

    task automatic test_reset();
        rstIn = 1'b1; enIn = 1'b1; modeIn = 1'b0; chEnIn = 4'hF; polIn = 4'hF;
        wrEnIn = 1'b0; wrChIn = '0; wrDutyIn = '0;
        repeat (3) tick();
        chk_cnt++; if (pwmOut !== 4'h0) $display("FAIL reset_pwm got %h exp 0", pwmOut); else pass_cnt++;
        chk_cnt++; if (periodStartOut !== 1'b0) $display("FAIL reset_pstart got %b exp 0", periodStartOut); else pass_cnt++;
    endtask

    task automatic test_edge();
        rstIn = 1'b0; polIn = 4'h0;
        drive_write(0, 64);
        tick();
        wrEnIn = 1'b0;
        chk_cnt++; if (periodStartOut !== 1'b1) $display("FAIL edge_first_pstart got %b exp 1", periodStartOut); else pass_cnt++;
        measure_period(-1, 0, -1, 0, 0);
        chk_cnt++; if (hc[0] !== 0) $display("FAIL edge_no_partial got %0d exp 0", hc[0]); else pass_cnt++;
        measure_period(-1, 0, -1, 0, 0);
        chk_cnt++; if (hc[0] !== 256) $display("FAIL edge_high0 got %0d exp 256", hc[0]); else pass_cnt++;
        chk_cnt++; if (fh[0] !== 0) $display("FAIL edge_first0 got %0d exp 0", fh[0]); else pass_cnt++;
        chk_cnt++; if (lh[0] !== 255) $display("FAIL edge_last0 got %0d exp 255", lh[0]); else pass_cnt++;
        chk_cnt++; if (hc[1] !== 0) $display("FAIL edge_high1 got %0d exp 0", hc[1]); else pass_cnt++;
        chk_cnt++; if (psc !== 1) $display("FAIL edge_pstart_count got %0d exp 1", psc); else pass_cnt++;
    endtask

    task automatic test_center();
        modeIn = 1'b1;
        measure_period(-1, 0, -1, 0, 0);
        chk_cnt++; if (fh[0] !== 0) $display("FAIL center_deferred got %0d exp 0", fh[0]); else pass_cnt++;
        measure_period(-1, 0, -1, 0, 0);
        chk_cnt++; if (hc[0] !== 256) $display("FAIL center_high0 got %0d exp 256", hc[0]); else pass_cnt++;
        chk_cnt++; if (fh[0] !== 384) $display("FAIL center_first0 got %0d exp 384", fh[0]); else pass_cnt++;
        chk_cnt++; if (lh[0] !== 639) $display("FAIL center_last0 got %0d exp 639", lh[0]); else pass_cnt++;
        chk_cnt++; if (hc[1] + hc[2] + hc[3] !== 0) $display("FAIL center_others got %0d exp 0", hc[1] + hc[2] + hc[3]); else pass_cnt++;
    endtask

    task automatic test_midperiod_write();
        modeIn = 1'b0;
        measure_period(5, 32, -1, 0, 1);
        chk_cnt++; if (hc[1] !== 0) $display("FAIL mid_pending_only got %0d exp 0", hc[1]); else pass_cnt++;
        measure_period(-1, 0, -1, 0, 1);
        chk_cnt++; if (hc[1] !== 128) $display("FAIL mid_duty32 got %0d exp 128", hc[1]); else pass_cnt++;
        measure_period(300, 200, 500, 128, 1);
        chk_cnt++; if (hc[1] !== 128) $display("FAIL mid_no_glitch got %0d exp 128", hc[1]); else pass_cnt++;
        measure_period(-1, 0, -1, 0, 1);
        chk_cnt++; if (hc[1] !== 512) $display("FAIL mid_last_wins got %0d exp 512", hc[1]); else pass_cnt++;
        chk_cnt++; if (lh[1] !== 511) $display("FAIL mid_last1 got %0d exp 511", lh[1]); else pass_cnt++;
        chk_cnt++; if (hc[0] !== 256) $display("FAIL mid_ch0_kept got %0d exp 256", hc[0]); else pass_cnt++;
    endtask

    task automatic test_boundary_write();
        measure_period(1022, 255, -1, 0, 2);
        chk_cnt++; if (hc[2] !== 0) $display("FAIL bnd_before got %0d exp 0", hc[2]); else pass_cnt++;
        measure_period(1022, 0, -1, 0, 2);
        chk_cnt++; if (hc[2] !== 1020) $display("FAIL bnd_max_duty got %0d exp 1020", hc[2]); else pass_cnt++;
        chk_cnt++; if (lh[2] !== 1019) $display("FAIL bnd_max_last got %0d exp 1019", lh[2]); else pass_cnt++;
        measure_period(-1, 0, -1, 0, 2);
        chk_cnt++; if (hc[2] !== 0) $display("FAIL bnd_zero_duty got %0d exp 0", hc[2]); else pass_cnt++;
    endtask

    task automatic test_pol_enable();
        int k;
        measure_period(10, 128, -1, 0, 3);
        measure_period(-1, 0, -1, 0, 3);
        chk_cnt++; if (hc[3] !== 512) $display("FAIL pol_plain got %0d exp 512", hc[3]); else pass_cnt++;
        polIn[3] = 1'b1;
        measure_period(-1, 0, -1, 0, 3);
        measure_period(-1, 0, -1, 0, 3);
        chk_cnt++; if (hc[3] !== 512) $display("FAIL pol_inv_high got %0d exp 512", hc[3]); else pass_cnt++;
        chk_cnt++; if (fh[3] !== 512) $display("FAIL pol_inv_first got %0d exp 512", fh[3]); else pass_cnt++;
        chk_cnt++; if (lh[3] !== 1023) $display("FAIL pol_inv_last got %0d exp 1023", lh[3]); else pass_cnt++;
        chEnIn[3] = 1'b0;
        tick();
        chk_cnt++; if (pwmOut[3] !== 1'b1) $display("FAIL chen_idle got %b exp 1", pwmOut[3]); else pass_cnt++;
        chEnIn[3] = 1'b1;
        tick();
        chk_cnt++; if (pwmOut[3] !== 1'b0) $display("FAIL chen_resume got %b exp 0", pwmOut[3]); else pass_cnt++;
        enIn = 1'b0;
        tick();
        chk_cnt++; if (pwmOut !== 4'b1000) $display("FAIL en_off_idle got %b exp 1000", pwmOut); else pass_cnt++;
        repeat (4) tick();
        chk_cnt++; if (pwmOut !== 4'b1000) $display("FAIL en_off_hold got %b exp 1000", pwmOut); else pass_cnt++;
        chk_cnt++; if (periodStartOut !== 1'b0) $display("FAIL en_off_pstart got %b exp 0", periodStartOut); else pass_cnt++;
        enIn = 1'b1;
        k = 0;
        do begin
            tick();
            k++;
        end while (periodStartOut !== 1'b1 && k < 2100);
        chk_cnt++; if (k !== 1022) $display("FAIL en_resume_cnt got %0d exp 1022", k); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        polIn = 4'hF;
        repeat (100) tick();
        rstIn = 1'b1;
        tick();
        chk_cnt++; if (pwmOut !== 4'h0) $display("FAIL rstmid_pwm got %h exp 0", pwmOut); else pass_cnt++;
        chk_cnt++; if (periodStartOut !== 1'b0) $display("FAIL rstmid_pstart got %b exp 0", periodStartOut); else pass_cnt++;
        rstIn = 1'b0; polIn = 4'h0;
        tick();
        chk_cnt++; if (periodStartOut !== 1'b1) $display("FAIL rstmid_cnt_zero got %b exp 1", periodStartOut); else pass_cnt++;
        measure_period(-1, 0, -1, 0, 0);
        chk_cnt++; if (hc[0] + hc[1] + hc[3] !== 0) $display("FAIL rstmid_active_clr got %0d exp 0", hc[0] + hc[1] + hc[3]); else pass_cnt++;
        measure_period(-1, 0, -1, 0, 0);
        chk_cnt++; if (hc[0] + hc[1] + hc[3] !== 0) $display("FAIL rstmid_pending_clr got %0d exp 0", hc[0] + hc[1] + hc[3]); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_edge();
        test_center();
        test_midperiod_write();
        test_boundary_write();
        test_pol_enable();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
